// File: rtl/mult4_sched_if.sv
// mult4_sched_if: operand requests from two sources plus the result port
// toward the downstream consumer.
//
// Handshakes:
//   requests - reqN stays high with stable aN/bN until gntN pulses for one
//              cycle; the requester drops reqN at the edge that ends that
//              cycle.
//   result   - res/res_id are valid while res_valid is high; the transfer
//              happens on a rising edge where res_valid and res_ready are
//              both high. res/res_id are held while res_ready is low.
interface mult4_sched_if;
  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       gnt0;
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       gnt1;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res;
  logic       res_id;
  logic       busy;

  // Requesters and consumer side
  modport master (
    output req0, a0, b0, req1, a1, b1, res_ready,
    input  gnt0, gnt1, res_valid, res, res_id, busy
  );

  // Scheduler side
  modport slave (
    input  req0, a0, b0, req1, a1, b1, res_ready,
    output gnt0, gnt1, res_valid, res, res_id, busy
  );
endinterface

// File: rtl/mult4_sched.sv
// mult4_sched: round-robin front-end that shares one combinational 4x4
// multiplier (mult4) between two requesters and returns the product with
// the winner's ID through a valid/ready result port.
// Optional macro MULT4_SCHED_PIPE_EN adds a register stage on the mult4
// output and a CALC2 state (one extra cycle of latency).

// Combinational 4x4 unsigned multiplier with bit-level ports.
module mult4 (
  input  logic x0, x1, x2, x3,
  input  logic y0, y1, y2, y3,
  output logic z0, z1, z2, z3, z4, z5, z6, z7
);
  logic [7:0] p;
  assign p = {4'b0000, x3, x2, x1, x0} * {4'b0000, y3, y2, y1, y0};
  assign {z7, z6, z5, z4, z3, z2, z1, z0} = p;
endmodule

module mult4_sched (
  input  logic               clk,
  input  logic               rst_n,
  mult4_sched_if.slave       bus,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       cur_id;
  logic       last_id;
  logic [7:0] res_q;
  logic       res_id_q;
  logic       res_valid_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       busy_q;
  logic [7:0] z;
  logic       win_any;
  logic       win_id;
`ifdef MULT4_SCHED_PIPE_EN
  logic [7:0] z_q;
`endif

  mult4 u_mult4 (
    .x0(op_a[0]), .x1(op_a[1]), .x2(op_a[2]), .x3(op_a[3]),
    .y0(op_b[0]), .y1(op_b[1]), .y2(op_b[2]), .y3(op_b[3]),
    .z0(z[0]), .z1(z[1]), .z2(z[2]), .z3(z[3]),
    .z4(z[4]), .z5(z[5]), .z6(z[6]), .z7(z[7])
  );

  // Round-robin pick: a lone request wins; on a tie the requester not
  // served last time wins.
  always_comb begin
    win_any = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) win_id = ~last_id;
    else                      win_id = bus.req1;
  end

  // Scheduler FSM with registered grant, result and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= 4'd0;
      op_b        <= 4'd0;
      cur_id      <= 1'b0;
      last_id     <= 1'b1;
      res_q       <= 8'd0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULT4_SCHED_PIPE_EN
      z_q         <= 8'd0;
`endif
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            op_a    <= win_id ? bus.a1 : bus.a0;
            op_b    <= win_id ? bus.b1 : bus.b0;
            cur_id  <= win_id;
            last_id <= win_id;
            gnt0_q  <= ~win_id;
            gnt1_q  <= win_id;
            busy_q  <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
`ifdef MULT4_SCHED_PIPE_EN
          z_q   <= z;
          state <= CALC2;
`else
          res_q       <= z;
          res_id_q    <= cur_id;
          res_valid_q <= 1'b1;
          state       <= DONE;
`endif
        end
        CALC2: begin
`ifdef MULT4_SCHED_PIPE_EN
          res_q       <= z_q;
          res_id_q    <= cur_id;
          res_valid_q <= 1'b1;
          state       <= DONE;
`else
          busy_q <= 1'b0;
          state  <= IDLE;
`endif
        end
        DONE: begin
          // Stall holds res/res_id/res_valid; no grant is issued from here.
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.res       = res_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_mult4_sched.sv
// tb_mult4_sched: directed and randomized checks of mult4_sched against a
// transaction-level model (round-robin winner prediction and a*b products
// held in an expected queue).
module tb_mult4_sched;
`ifdef MULT4_SCHED_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  mult4_sched_if bus ();

  mult4_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // Model state and scoreboard
  int         checks = 0;
  int         errors = 0;
  logic       pend0, pend1;
  logic [3:0] ma [2];
  logic [3:0] mb [2];
  logic       last_w;
  logic [8:0] exp_q [$];
  bit         rdy_rand;
  bit         gen_rand;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic raise(input logic id, input logic [3:0] a, input logic [3:0] b);
    ma[id] = a;
    mb[id] = b;
    if (id) begin pend1 = 1'b1; bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
    else    begin pend0 = 1'b1; bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
  endtask

  task automatic drop(input logic id);
    if (id) begin pend1 = 1'b0; bus.req1 = 1'b0; end
    else    begin pend0 = 1'b0; bus.req0 = 1'b0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    drop(1'b0);
    drop(1'b1);
    last_w = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One clock of model tracking; called at a negedge, returns at the next.
  task automatic cycle();
    logic       take, stall, gid, pred;
    logic [7:0] r, p;
    logic       rid;
    logic [8:0] e;
    take  = bus.res_valid & bus.res_ready;
    stall = bus.res_valid & ~bus.res_ready;
    r     = bus.res;
    rid   = bus.res_id;
    @(negedge clk);
    if (take) begin
      if (exp_q.size() == 0) begin
        check("res_spurious", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("res_val", 32'(r), 32'(e[7:0]));
        check("res_id", 32'(rid), 32'(e[8]));
      end
    end
    if (stall)
      check("stall_hold", {22'd0, bus.res_valid, bus.res_id, bus.res}, {22'd0, 1'b1, rid, r});
    if (bus.gnt0 | bus.gnt1) begin
      check("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      gid = bus.gnt1;
      check("gnt_pending", 32'(gid ? pend1 : pend0), 32'd1);
      pred = (pend0 & pend1) ? ~last_w : pend1;
      check("gnt_arb", 32'(gid), 32'(pred));
      p = {4'b0000, ma[gid]} * {4'b0000, mb[gid]};
      exp_q.push_back({gid, p});
      last_w = gid;
      drop(gid);
    end
    if (gen_rand) begin
      if (!pend0 && $urandom_range(0, 3) == 0)
        raise(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (!pend1 && $urandom_range(0, 3) == 0)
        raise(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    if (rdy_rand) bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend0 || pend1 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(pend0 | pend1 | (exp_q.size() != 0)), 32'd0);
  endtask

  logic [3:0] bnd_a [5];
  logic [3:0] bnd_b [5];
  logic [7:0] held_res;
  logic       held_id;
  int         waited;

  // Directed sequence followed by randomized traffic
  initial begin
    rst_n         = 1'b0;
    bus.req0      = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0;
    bus.req1      = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0;
    bus.res_ready = 1'b1;
    rdy_rand      = 1'b0;
    gen_rand      = 1'b0;
    pend0         = 1'b0;
    pend1         = 1'b0;
    last_w        = 1'b1;

    // Reset values
    do_reset();
    check("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single request with latency checks: 1011 x 0101
    raise(1'b0, 4'b1011, 4'b0101);
    cycle();
    check("single_gnt0", 32'(bus.gnt0), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd1);
    check("single_early", 32'(bus.res_valid), 32'd0);
    for (int i = 0; i < LAT - 2; i++) begin
      cycle();
      check("single_early", 32'(bus.res_valid), 32'd0);
      check("single_gnt_once", 32'(bus.gnt0), 32'd0);
    end
    cycle();
    check("single_gnt_once", 32'(bus.gnt0), 32'd0);
    check("single_valid", 32'(bus.res_valid), 32'd1);
    check("single_res", 32'(bus.res), 32'h37);
    check("single_res_id", 32'(bus.res_id), 32'd0);
    drain(20);
    check("single_idle_busy", 32'(bus.busy), 32'd0);
    check("single_idle_valid", 32'(bus.res_valid), 32'd0);

    // Tie after reset, then tie again
    do_reset();
    raise(1'b0, 4'b1010, 4'b1101);
    raise(1'b1, 4'b0110, 4'b1001);
    drain(40);
    raise(1'b0, 4'b1010, 4'b1101);
    raise(1'b1, 4'b0110, 4'b1001);
    cycle();
    check("tie_again_gnt0", 32'(bus.gnt0), 32'd1);
    drain(40);

    // Boundary products
    bnd_a[0] = 4'b1111; bnd_b[0] = 4'b1111;
    bnd_a[1] = 4'b1111; bnd_b[1] = 4'b1110;
    bnd_a[2] = 4'b1111; bnd_b[2] = 4'b0000;
    bnd_a[3] = 4'b1000; bnd_b[3] = 4'b0100;
    bnd_a[4] = 4'b1010; bnd_b[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      raise(1'(i % 2), bnd_a[i], bnd_b[i]);
      drain(20);
    end

    // Backpressure with requester 1 pending
    bus.res_ready = 1'b0;
    raise(1'b0, 4'd7, 4'd9);
    waited = 0;
    while (!bus.res_valid && waited < 10) begin
      cycle();
      waited++;
    end
    check("bp_valid", 32'(bus.res_valid), 32'd1);
    held_res = bus.res;
    held_id  = bus.res_id;
    raise(1'b1, 4'd3, 4'd5);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_busy", 32'(bus.busy), 32'd1);
      check("bp_no_gnt1", 32'(bus.gnt1), 32'd0);
      check("bp_res", 32'(bus.res), 32'(held_res));
      check("bp_res_id", 32'(bus.res_id), 32'(held_id));
    end
    bus.res_ready = 1'b1;
    cycle();
    check("bp_release_valid", 32'(bus.res_valid), 32'd0);
    check("bp_release_gnt1", 32'(bus.gnt1), 32'd0);
    cycle();
    check("bp_gnt1", 32'(bus.gnt1), 32'd1);
    drain(20);

    // Reset during CALC
    do_reset();
    raise(1'b0, 4'd5, 4'd6);
    raise(1'b1, 4'd2, 4'd3);
    cycle();
    check("mid_gnt0", 32'(bus.gnt0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_res", 32'(bus.res), 32'd0);
    check("mid_rst_res_id", 32'(bus.res_id), 32'd0);
    exp_q.delete();
    last_w = 1'b1;
    @(negedge clk);
    check("mid_rst_no_valid", 32'(bus.res_valid), 32'd0);
    rst_n = 1'b1;
    raise(1'b0, 4'd9, 4'd9);
    cycle();
    check("mid_tie_gnt0", 32'(bus.gnt0), 32'd1);
    drain(40);

    // Randomized traffic with random backpressure
    rdy_rand = 1'b1;
    gen_rand = 1'b1;
    repeat (600) cycle();
    gen_rand = 1'b0;
    drain(200);
    rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult4_sched.md
# mult4_sched

Sequential front-end that shares a single combinational `mult4` 4×4 unsigned multiplier between two requesters. It arbitrates round-robin, captures the winner's operands into registers that drive the `mult4` bit ports, and returns the 8-bit product with the winner's ID through a valid/ready result port. It sits between the two operand sources and the downstream consumer, and is the only instance driving `mult4` inputs.

## Interface
- No parameters.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` input 1: requester 0 has operands pending.
- `a0` input 4: requester 0 multiplicand (unsigned).
- `b0` input 4: requester 0 multiplier (unsigned).
- `gnt0` output 1: one-cycle pulse; requester 0 operands were captured.
- `req1` input 1: requester 1 has operands pending.
- `a1` input 4: requester 1 multiplicand (unsigned).
- `b1` input 4: requester 1 multiplier (unsigned).
- `gnt1` output 1: one-cycle pulse; requester 1 operands were captured.
- `res_valid` output 1: `res`/`res_id` hold a valid product.
- `res_ready` input 1: consumer accepts the result.
- `res` output 8: product `a*b`, bit 7 MSB.
- `res_id` output 1: requester that owns `res`.
- `busy` output 1: high in every state except IDLE.

## Operation
- Registers:
  - `op_a[3:0]` and `op_b[3:0]` drive `mult4` `x0..x3` and `y0..y3`.
  - `mult4` `z0..z7` feed the `res` register.
  - `last_id` holds the requester served most recently.
- FSM states: IDLE, CALC, (CALC2 only with pipeline macro), DONE.
- IDLE:
  - Samples `req0`/`req1` each cycle.
  - If exactly one is high, that requester wins.
  - If both are high, the requester not equal to `last_id` wins.
  - On a win: load `op_a`/`op_b` from the winner, set `cur_id` and `last_id` to the winner, assert the winner's `gnt` next cycle, go to CALC.
  - With no request, stay in IDLE.
- CALC: load `res` from `z7..z0` and `res_id` from `cur_id`, then go to DONE (or to CALC2 with the macro).
- DONE:
  - `res_valid`=1.
  - If `res_ready`=1, the handshake completes on this edge and the FSM returns to IDLE.
  - Otherwise hold `res`, `res_id` and `res_valid` unchanged (stall). No new grant is issued while stalled.
- Arithmetic: full 8-bit unsigned product; no truncation or overflow is possible (15×15=225).
- Requester protocol:
  - Keep `req` high with stable operands until `gnt` is seen.
  - Drop `req` at the edge ending the `gnt` cycle.
  - A `req` still high when the FSM next reaches IDLE is treated as a new request.
- Reset values: `gnt0`=`gnt1`=0, `res_valid`=0, `res`=0x00, `res_id`=0, `busy`=0, `op_a`=`op_b`=0, `last_id`=1 (requester 0 wins the first tie), state IDLE.
- Reset mid-operation: the in-flight transaction is discarded with no result and no further `gnt`. The requester must re-request after reset.

## Timing
- Edge E0 (IDLE, request sampled) → `gnt`=1 during cycle E0+1 (CALC).
- At edge E1, `res` is loaded → `res_valid`=1 from cycle E1+1.
- Request-to-valid latency is 2 cycles (3 with the macro).
- Minimum issue interval is 3 cycles (4 with the macro) when `res_ready` is tied high.
- `gnt0` and `gnt1` are never high in the same cycle.
- `gnt` pulses exactly once per accepted request.
- `res` must not change while `res_valid`=1 and `res_ready`=0.
- `busy` is high in CALC, CALC2 and DONE.

## Configuration
- `MULT4_SCHED_PIPE_EN` defined:
  - Adds a register stage on `z7..z0` and the CALC2 state.
  - CALC captures the `mult4` output; CALC2 loads `res`.
  - Latency +1 cycle; shortens the critical path through `mult4`.
- Undefined: no CALC2; `res` is loaded directly from `mult4` in CALC.
- The handshake, arbitration and reset behaviour are identical in both builds.

## Test plan
- Single request: `req0`, a0=1011, b0=0101 → one `gnt0` pulse; `res_valid` after 2 cycles (3 with macro) with `res`=00110111, `res_id`=0.
- Simultaneous requests after reset:
  - Stimulus: req0 with 1010×1101 and req1 with 0110×1001, both held.
  - Required: `gnt0` first, `res`=10000010/`res_id`=0; then `gnt1`, `res`=00110110/`res_id`=1.
  - Both requests then held again: `gnt0` is next.
- Boundary products: 1111×1111 → 11100001; 1111×1110 → 11010010; 1111×0000 → 00000000; 1000×0100 → 00100000; 1010×0001 → 00001010.
- Backpressure: hold `res_ready`=0 for 5 cycles in DONE with req1 pending → `res`/`res_id` stable, `busy`=1, no `gnt1`. Release → `gnt1` on the first IDLE cycle after the handshake.
- Reset mid-operation: assert `rst_n`=0 during CALC → all outputs return to reset values immediately; no `res_valid` for that transaction; the next tie goes to requester 0.
